// File: rtl/contador_pkg.sv
// contador_pkg: shared constants and helpers for the contador counter family
//   DIR_UP / DIR_DOWN : encodings of the up input
//   clog2             : bit width needed to hold 0..n-1, never less than 1
package contador_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Floors at 1 so a PRESCALE of 1 still gets a legal one-bit register.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler: divides enabled cycles by PRESCALE to produce a count tick
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset, clears the phase
//   en   in  phase advances only while high, holds otherwise
//   clr  in  restarts the phase at 0 (used by parallel load)
//   tick out high on every PRESCALE-th enabled cycle
module contador_prescaler
   import contador_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("contador_prescaler: PRESCALE must be >= 1");
   end

   localparam int PW = clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q, cnt_d;
   logic          last;

   // With PRESCALE=1 the phase sits at 0, last is constant 1 and tick reduces to en.
   assign last = cnt_q == LAST;
   assign tick = en && last;

   always_comb begin
      cnt_d = clr ? '0 : !en ? cnt_q : last ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/contador_mod_param.sv
// contador_mod_param: parametrised modulo-N up/down counter with load, prescaler, tc and wrap
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   count enable (prescaler and counter hold while low)
//   up       in   direction, DIR_UP increments, DIR_DOWN decrements
//   load     in   parallel load strobe, beats stepping and ignores en
//   load_val in   value to load, clamped to MODULUS-1
//   q        out  registered count, always < MODULUS
//   tc       out  terminal count for the current direction (combinational)
//   wrap     out  registered one-cycle pulse after a step that wrapped
// Build option: define CONTADOR_SAT_EN for saturating mode (hold at terminal value, wrap stays 0).
module contador_mod_param
   import contador_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
      $error("contador_mod_param: MODULUS must be in 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_q, q_d, stepped;
   logic             wrap_q, wrap_d;
   logic             tick, at_top, at_bot, term;

   contador_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (load),
      .tick(tick)
   );

   assign at_top = q_q == MAX;
   assign at_bot = q_q == '0;
   assign term   = (up == DIR_UP) ? at_top : at_bot;

   // Wrap against MODULUS explicitly so arithmetic never relies on 2**WIDTH rollover.
`ifdef CONTADOR_SAT_EN
   assign stepped = term ? q_q : (up == DIR_DOWN) ? q_q - 1'b1 : q_q + 1'b1;
`else
   assign stepped = (up == DIR_DOWN) ? (at_bot ? MAX : q_q - 1'b1)
                                     : (at_top ? '0 : q_q + 1'b1);
`endif

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (load) begin
         q_d = (load_val > MAX) ? MAX : load_val;
      end else if (tick) begin
         q_d = stepped;
`ifndef CONTADOR_SAT_EN
         wrap_d = term;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign tc   = term;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_contador_mod_param.sv
// tb_contador_mod_param: scoreboard bench comparing the counter against an integer reference model
module tb_contador_mod_param;

   localparam int W = 4;
   localparam int M = 10;
   localparam int P = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q;
   logic         tc, wrap;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int q;
      bit wrap;
   } exp_t;

   exp_t sb[$];
   int   m_q = 0, m_ph = 0, nxt = 0;
   bit   m_wrap = 1'b0;
   exp_t e;

   always #5 clk = ~clk;

   contador_mod_param #(.WIDTH(W), .MODULUS(M), .PRESCALE(P)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up      (up),
      .load    (load),
      .load_val(load_val),
      .q       (q),
      .tc      (tc),
      .wrap    (wrap)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: count as a plain integer modulo M, phase as a count of enabled cycles modulo P.
   always @(posedge clk) begin : model
      if (rst) begin
         m_q = 0; m_ph = 0; m_wrap = 0;
      end else if (load) begin
         m_q = (int'(load_val) >= M) ? M - 1 : int'(load_val);
         m_ph = 0; m_wrap = 0;
      end else if (en) begin
         m_ph = (m_ph + 1) % P;
         m_wrap = 0;
         if (m_ph == 0) begin
            nxt = up ? m_q + 1 : m_q - 1;
`ifdef CONTADOR_SAT_EN
            m_q = (nxt < 0) ? 0 : (nxt >= M) ? M - 1 : nxt;
`else
            m_wrap = (nxt < 0) || (nxt >= M);
            m_q = (nxt + M) % M;
`endif
         end
      end else begin
         m_wrap = 0;
      end
      sb.push_back('{m_q, m_wrap});
   end

   always @(posedge clk) begin : monitor
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
         e = sb.pop_front();
         check("q", 32'(q), 32'(e.q));
         check("wrap", 32'(wrap), 32'(e.wrap));
         check("tc", 32'(tc), 32'(up ? (e.q == M - 1) : (e.q == 0)));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc(2);
      rst = 0; en = 1; up = 1;
      cyc(3 * M + 6);
      up = 0;
      cyc(3 * M + 6);
      load = 1; load_val = 4'd12;
      cyc(1);
      en = 0; load_val = 4'd3;
      cyc(1);
      load = 0;
      cyc(4);
      en = 1; up = 1;
      cyc(4);
      en = 0;
      cyc(2);
      en = 1;
      cyc(7);
      load = 1; load_val = 4'd7;
      cyc(1);
      load = 0;
      cyc(2);
      rst = 1;
      cyc(1);
      rst = 0;
      cyc(8);
      load = 1; load_val = 4'd9;
      cyc(1);
      load = 0; up = 1;
      cyc(6);
      up = 0; load = 1; load_val = 4'd0;
      cyc(1);
      load = 0;
      cyc(6);
      for (int i = 0; i < 600; i++) begin
         en       = $urandom_range(0, 3) != 0;
         up       = (i % 40 < 20) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
         load     = $urandom_range(0, 15) == 0;
         load_val = W'($urandom_range(0, 15));
         rst      = $urandom_range(0, 63) == 0;
         cyc(1);
      end
      rst = 0; load = 0; en = 0;
      cyc(2);
      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
